// File: rtl/smi_mem_lib_read_unpack32.sv
// Unpacks 64-bit burst read words into a 32-bit element stream, then reports one status token per transfer.
// Optional build macro SMI_UNPACK32_SWAP_EN emits the upper half of each word first.
module smi_mem_lib_read_unpack32 #(
  parameter int CountWidth = 32
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  paramsValid,
  input  logic [CountWidth-1:0] paramElemCount,
  output logic                  paramsStop,
  input  logic                  readValid,
  input  logic [63:0]           readData,
  output logic                  readStop,
  input  logic                  doneValid,
  input  logic                  doneStatusOk,
  output logic                  doneStop,
  output logic                  elemValid,
  output logic [31:0]           elemData,
  output logic                  elemLast,
  input  logic                  elemStop,
  output logic                  statusValid,
  output logic                  statusOk,
  input  logic                  statusStop
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_EMIT_LOW  = 3'd2,
    ST_EMIT_HIGH = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_REPORT    = 3'd5
  } state_t;

  localparam logic [CountWidth-1:0] CountZero = {CountWidth{1'b0}};
  localparam logic [CountWidth-1:0] CountOne  = {{(CountWidth-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [CountWidth-1:0] remaining_q, remaining_d;
  logic [63:0]           word_q, word_d;
  logic                  status_ok_q, status_ok_d;
  logic [31:0]           first_half_s, second_half_s;
  logic                  is_last_s;

  // Saturating decrement keeps the counter from wrapping below zero.
  function automatic logic [CountWidth-1:0] dec_sat(input logic [CountWidth-1:0] value);
    if (value == CountZero) begin
      dec_sat = CountZero;
    end else begin
      dec_sat = value - CountOne;
    end
  endfunction

`ifdef SMI_UNPACK32_SWAP_EN
  assign first_half_s  = word_q[63:32];
  assign second_half_s = word_q[31:0];
`else
  assign first_half_s  = word_q[31:0];
  assign second_half_s = word_q[63:32];
`endif

  assign is_last_s = (remaining_q == CountOne);

  // State register; the only reset flop in the block.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers, deliberately non-resettable.
  always_ff @(posedge clk) begin
    remaining_q <= remaining_d;
    word_q      <= word_d;
    status_ok_q <= status_ok_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    word_d      = word_q;
    status_ok_d = status_ok_q;
    paramsStop  = 1'b1;
    readStop    = 1'b1;
    doneStop    = 1'b1;
    elemValid   = 1'b0;
    elemData    = first_half_s;
    elemLast    = 1'b0;
    statusValid = 1'b0;
    statusOk    = status_ok_q;

    case (state_q)
      ST_IDLE: begin
        paramsStop = 1'b0;
        if (paramsValid) begin
          remaining_d = paramElemCount;
          state_d     = (paramElemCount == CountZero) ? ST_WAIT_DONE : ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        readStop = 1'b0;
        if (readValid) begin
          word_d  = readData;
          state_d = ST_EMIT_LOW;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_EMIT_LOW: begin
        elemValid = 1'b1;
        elemData  = first_half_s;
        elemLast  = is_last_s;
        if (!elemStop) begin
          remaining_d = dec_sat(remaining_q);
          state_d     = is_last_s ? ST_WAIT_DONE : ST_EMIT_HIGH;
        end else begin
          state_d = ST_EMIT_LOW;
        end
      end
      ST_EMIT_HIGH: begin
        elemValid = 1'b1;
        elemData  = second_half_s;
        elemLast  = is_last_s;
        // Fetch the next word in the same cycle the upper element leaves, for 1 element/cycle.
        readStop  = is_last_s ? 1'b1 : elemStop;
        if (!elemStop) begin
          remaining_d = dec_sat(remaining_q);
          if (is_last_s) begin
            state_d = ST_WAIT_DONE;
          end else if (readValid) begin
            word_d  = readData;
            state_d = ST_EMIT_LOW;
          end else begin
            state_d = ST_FETCH;
          end
        end else begin
          state_d = ST_EMIT_HIGH;
        end
      end
      ST_WAIT_DONE: begin
        doneStop = 1'b0;
        if (doneValid) begin
          status_ok_d = doneStatusOk;
          state_d     = ST_REPORT;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_REPORT: begin
        statusValid = 1'b1;
        if (!statusStop) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REPORT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_smi_mem_lib_read_unpack32.sv
// Table-driven bench for smi_mem_lib_read_unpack32 plus a mid-transfer srst sequence.
module tb_smi_mem_lib_read_unpack32;

  logic        clk = 1'b0;
  logic        srst;
  logic        paramsValid;
  logic [31:0] paramElemCount;
  logic        paramsStop;
  logic        readValid;
  logic [63:0] readData;
  logic        readStop;
  logic        doneValid;
  logic        doneStatusOk;
  logic        doneStop;
  logic        elemValid;
  logic [31:0] elemData;
  logic        elemLast;
  logic        elemStop;
  logic        statusValid;
  logic        statusOk;
  logic        statusStop;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  smi_mem_lib_read_unpack32 #(.CountWidth(32)) dut (
    .clk(clk), .srst(srst),
    .paramsValid(paramsValid), .paramElemCount(paramElemCount), .paramsStop(paramsStop),
    .readValid(readValid), .readData(readData), .readStop(readStop),
    .doneValid(doneValid), .doneStatusOk(doneStatusOk), .doneStop(doneStop),
    .elemValid(elemValid), .elemData(elemData), .elemLast(elemLast), .elemStop(elemStop),
    .statusValid(statusValid), .statusOk(statusOk), .statusStop(statusStop)
  );

  typedef struct packed {
    logic [31:0]      count;
    logic [2:0]       nwords;
    logic [2:0][63:0] words;
    logic             done_ok;
    logic             stall;
    logic             early;
    logic             consec;
    logic [2:0]       exp_n;
    logic [5:0][31:0] exp_elem;
    logic [2:0]       exp_words;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_at(input vec_t v, input int k);
`ifdef SMI_UNPACK32_SWAP_EN
    logic [63:0] w;
    w = v.words[k/2];
    exp_at = (k % 2 == 0) ? w[63:32] : w[31:0];
`else
    exp_at = v.exp_elem[k];
`endif
  endfunction

  task automatic idle_inputs();
    paramsValid = 1'b0; paramElemCount = 32'd0;
    readValid = 1'b0; readData = 64'd0;
    doneValid = 1'b0; doneStatusOk = 1'b0;
    elemStop = 1'b0; statusStop = 1'b0;
  endtask

  // Runs one transfer from the table; called just after a falling edge.
  task automatic run_vec(input int vi);
    vec_t v;
    int qi = 0, got = 0, cyc = 0, first_cyc = -1, last_cyc = -1;
    bit pdone = 1'b0, ddone = 1'b0, sdone = 1'b0, read_hold = 1'b0;
    logic [6:0] pat = 7'b0110101;
    v = vecs[vi];
    while (!sdone && cyc < 300) begin
      paramsValid    = !pdone;
      paramElemCount = v.count;
      readValid      = (qi < int'(v.nwords)) && (read_hold || !(v.stall && (cyc % 3 == 0)));
      readData       = (qi < 3) ? v.words[qi] : 64'd0;
      doneValid      = !ddone && (v.early || got >= int'(v.exp_n));
      doneStatusOk   = v.done_ok;
      elemStop       = v.stall ? pat[cyc % 7] : 1'b0;
      statusStop     = v.stall ? 1'((cyc % 2) == 1) : 1'b0;
      #1;
      if (paramsValid && !paramsStop) pdone = 1'b1;
      read_hold = readValid && readStop;
      if (readValid && !readStop) qi++;
      if (elemValid && !elemStop) begin
        if (got < int'(v.exp_n)) begin
          chk($sformatf("v%0d_elem%0d_data", vi, got), 64'(elemData), 64'(exp_at(v, got)));
          chk($sformatf("v%0d_elem%0d_last", vi, got), 64'(elemLast), 64'(got == int'(v.exp_n) - 1));
        end else begin
          chk($sformatf("v%0d_extra_elem", vi), 64'(got + 1), 64'(v.exp_n));
        end
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        got++;
      end
      if (doneValid && !doneStop) begin
        ddone = 1'b1;
        chk($sformatf("v%0d_done_after_last", vi), 64'(got), 64'(v.exp_n));
      end
      if (statusValid && !statusStop) begin
        sdone = 1'b1;
        chk($sformatf("v%0d_status_ok", vi), 64'(statusOk), 64'(v.done_ok));
      end
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("v%0d_completed", vi), 64'(sdone), 64'd1);
    chk($sformatf("v%0d_elem_count", vi), 64'(got), 64'(v.exp_n));
    chk($sformatf("v%0d_words_consumed", vi), 64'(qi), 64'(v.exp_words));
    if (v.consec) chk($sformatf("v%0d_elem_span", vi), 64'(last_cyc - first_cyc), 64'(int'(v.exp_n) - 1));
    idle_inputs();
  endtask

  initial begin
    vecs[0] = '{count: 32'd4, nwords: 3'd2,
                words: {64'd0, 64'h0000000400000003, 64'h0000000200000001},
                done_ok: 1'b1, stall: 1'b0, early: 1'b0, consec: 1'b1, exp_n: 3'd4,
                exp_elem: {32'd0, 32'd0, 32'd4, 32'd3, 32'd2, 32'd1}, exp_words: 3'd2};
    vecs[1] = '{count: 32'd3, nwords: 3'd3,
                words: {64'h0000000600000005, 64'h0000000400000003, 64'h0000000200000001},
                done_ok: 1'b1, stall: 1'b0, early: 1'b0, consec: 1'b0, exp_n: 3'd3,
                exp_elem: {32'd0, 32'd0, 32'd0, 32'd3, 32'd2, 32'd1}, exp_words: 3'd2};
    vecs[2] = '{count: 32'd0, nwords: 3'd1,
                words: {64'd0, 64'd0, 64'h0000000200000001},
                done_ok: 1'b0, stall: 1'b0, early: 1'b0, consec: 1'b0, exp_n: 3'd0,
                exp_elem: {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, exp_words: 3'd0};
    vecs[3] = '{count: 32'd6, nwords: 3'd3,
                words: {64'h0000000600000005, 64'h0000000400000003, 64'h0000000200000001},
                done_ok: 1'b1, stall: 1'b1, early: 1'b1, consec: 1'b0, exp_n: 3'd6,
                exp_elem: {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1}, exp_words: 3'd3};
    vecs[4] = '{count: 32'd2, nwords: 3'd1,
                words: {64'd0, 64'd0, 64'h0000000800000007},
                done_ok: 1'b0, stall: 1'b0, early: 1'b1, consec: 1'b0, exp_n: 3'd2,
                exp_elem: {32'd0, 32'd0, 32'd0, 32'd0, 32'd8, 32'd7}, exp_words: 3'd1};
    vecs[5] = '{count: 32'd2, nwords: 3'd1,
                words: {64'd0, 64'd0, 64'h0000000A00000009},
                done_ok: 1'b1, stall: 1'b0, early: 1'b0, consec: 1'b1, exp_n: 3'd2,
                exp_elem: {32'd0, 32'd0, 32'd0, 32'd0, 32'd10, 32'd9}, exp_words: 3'd1};

    idle_inputs();
    srst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    srst = 1'b0;
    #1;
    chk("rst_paramsStop", 64'(paramsStop), 64'd0);
    chk("rst_readStop", 64'(readStop), 64'd1);
    chk("rst_doneStop", 64'(doneStop), 64'd1);
    chk("rst_elemValid", 64'(elemValid), 64'd0);
    chk("rst_statusValid", 64'(statusValid), 64'd0);
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(i);

    // Drive into EmitHigh, hold it with elemStop, then pulse srst.
    paramsValid = 1'b1; paramElemCount = 32'd4;
    @(negedge clk);
    paramsValid = 1'b0; readValid = 1'b1; readData = 64'h0000000C0000000B;
    @(negedge clk);
    readValid = 1'b0; elemStop = 1'b0;
    @(negedge clk);
    elemStop = 1'b1;
    #1;
    chk("srst_pre_elemValid", 64'(elemValid), 64'd1);
`ifdef SMI_UNPACK32_SWAP_EN
    chk("srst_pre_elemData", 64'(elemData), 64'h0B);
`else
    chk("srst_pre_elemData", 64'(elemData), 64'h0C);
`endif
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0; elemStop = 1'b0;
    #1;
    chk("srst_elemValid", 64'(elemValid), 64'd0);
    chk("srst_paramsStop", 64'(paramsStop), 64'd0);
    chk("srst_statusValid", 64'(statusValid), 64'd0);
    @(negedge clk);
    run_vec(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
